// File: rtl/snoopy_vertical_physics.sv
// Vertical motion engine for Snoopy: signed velocity plus gravity, multi-jump, ceiling/ground clamps.
// Optional build macro SNOOPY_VAR_JUMP_EN: releasing the button while rising halves upward speed.
module snoopy_vertical_physics #(
    parameter int Y_WIDTH      = 8,
    parameter int VEL_WIDTH    = 5,
    parameter int GROUND_Y     = 100,
    parameter int CEIL_Y       = 0,
    parameter int JUMP_VEL     = 6,
    parameter int GRAVITY      = 1,
    parameter int MAX_FALL_VEL = 7,
    parameter int MAX_JUMPS    = 2,
    localparam int CNT_W       = $clog2(MAX_JUMPS + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic                        jump_in,
    output logic [Y_WIDTH-1:0]          snoopy_y,
    output logic signed [VEL_WIDTH-1:0] velocity,
    output logic                        on_ground,
    output logic                        landed,
    output logic [CNT_W-1:0]            jump_count
);

    // Two guard bits keep y+vel and y-JUMP_VEL exact across both limits before truncation.
    localparam int EW = Y_WIDTH + 2;
    localparam logic signed [EW-1:0]        GROUND_E  = EW'(GROUND_Y);
    localparam logic signed [EW-1:0]        CEIL_E    = EW'(CEIL_Y);
    localparam logic signed [EW-1:0]        JUMP_E    = EW'(JUMP_VEL);
    localparam logic signed [EW-1:0]        GRAV_E    = EW'(GRAVITY);
    localparam logic signed [EW-1:0]        MAXF_E    = EW'(MAX_FALL_VEL);
    localparam logic signed [VEL_WIDTH-1:0] JUMP_V    = VEL_WIDTH'(-JUMP_VEL);
    localparam logic [CNT_W-1:0]            MAX_CNT   = CNT_W'(MAX_JUMPS);

    typedef enum logic [1:0] {
        S_GROUND = 2'd0,
        S_RISE   = 2'd1,
        S_FALL   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [Y_WIDTH-1:0]            y_q, y_d;
    logic signed [VEL_WIDTH-1:0]   vel_q, vel_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          landed_q, landed_d;
    logic                          jump_req_q, jump_req_d;
    logic                          jump_prev_q;

    logic                          jump_edge;
    logic                          req_now;
    logic signed [EW-1:0]          y_ext;
    logic signed [EW-1:0]          vel_ext;
    logic signed [EW-1:0]          vel_base;
    logic signed [EW-1:0]          vel_fall;
    logic signed [EW-1:0]          y_fall;
    logic signed [EW-1:0]          y_jump;

    function automatic logic signed [EW-1:0] sat_hi(input logic signed [EW-1:0] a,
                                                     input logic signed [EW-1:0] hi);
        return (a > hi) ? hi : a;
    endfunction

    function automatic logic signed [EW-1:0] sat_lo(input logic signed [EW-1:0] a,
                                                     input logic signed [EW-1:0] lo);
        return (a < lo) ? lo : a;
    endfunction

    always_comb begin
        jump_edge = jump_in & ~jump_prev_q;
        req_now   = jump_req_q | jump_edge;
        y_ext     = $signed({2'b00, y_q});
        vel_ext   = EW'(vel_q);
        vel_base  = vel_ext;
`ifdef SNOOPY_VAR_JUMP_EN
        if ((state_q == S_RISE) && !jump_in && (vel_ext < -EW'(1))) begin
            vel_base = vel_ext >>> 1;
        end
`endif
        vel_fall  = sat_hi(vel_base + GRAV_E, MAXF_E);
        y_fall    = y_ext + vel_fall;
        y_jump    = sat_lo(y_ext - JUMP_E, CEIL_E);
    end

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        vel_d      = vel_q;
        cnt_d      = cnt_q;
        landed_d   = 1'b0;
        jump_req_d = jump_req_q | jump_edge;

        if (frame_tick) begin
            // A tick always consumes the request, including an edge arriving on this very clock.
            jump_req_d = 1'b0;
            if (req_now && ((state_q == S_GROUND) || (cnt_q < MAX_CNT))) begin
                state_d = S_RISE;
                y_d     = y_jump[Y_WIDTH-1:0];
                vel_d   = JUMP_V;
                cnt_d   = (state_q == S_GROUND) ? CNT_W'(1) : cnt_q + CNT_W'(1);
            end else if (state_q != S_GROUND) begin
                if (y_fall >= GROUND_E) begin
                    state_d  = S_GROUND;
                    y_d      = GROUND_E[Y_WIDTH-1:0];
                    vel_d    = '0;
                    cnt_d    = '0;
                    landed_d = 1'b1;
                end else if (y_fall <= CEIL_E) begin
                    state_d = S_FALL;
                    y_d     = CEIL_E[Y_WIDTH-1:0];
                    vel_d   = '0;
                end else begin
                    state_d = (vel_fall < 0) ? S_RISE : S_FALL;
                    y_d     = y_fall[Y_WIDTH-1:0];
                    vel_d   = vel_fall[VEL_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_GROUND;
            y_q         <= GROUND_E[Y_WIDTH-1:0];
            vel_q       <= '0;
            cnt_q       <= '0;
            landed_q    <= 1'b0;
            jump_req_q  <= 1'b0;
            jump_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            cnt_q       <= cnt_d;
            landed_q    <= landed_d;
            jump_req_q  <= jump_req_d;
            jump_prev_q <= jump_in;
        end
    end

    assign snoopy_y   = y_q;
    assign velocity   = vel_q;
    assign on_ground  = (state_q == S_GROUND);
    assign landed     = landed_q;
    assign jump_count = cnt_q;

endmodule

// File: tb/tb_snoopy_vertical_physics.sv
// Randomised and directed bench for snoopy_vertical_physics: a default instance and one with CEIL_Y=90,
// both compared every clock against an integer reference model of the motion rules.
module tb_snoopy_vertical_physics;

    localparam int GND   = 100;
    localparam int JV    = 6;
    localparam int GRAV  = 1;
    localparam int MAXF  = 7;
    localparam int MAXJ  = 2;

    logic clk = 1'b0;
    logic rst, tick, jin;
    logic [7:0]        y0, y1;
    logic signed [4:0] v0, v1;
    logic              og0, og1, ld0, ld1;
    logic [1:0]        jc0, jc1;

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance: 0 = default ceiling, 1 = ceiling at 90.
    int m_y[2], m_v[2], m_air[2], m_rise[2], m_cnt[2], m_land[2], m_req[2], m_prev[2];
    int m_ceil[2] = '{0, 90};
    int sj_tbl[13] = '{94, 89, 85, 82, 80, 79, 79, 80, 82, 85, 89, 94, 100};

    always #5 clk = ~clk;

    snoopy_vertical_physics dut0 (
        .clock(clk), .reset(rst), .frame_tick(tick), .jump_in(jin),
        .snoopy_y(y0), .velocity(v0), .on_ground(og0), .landed(ld0), .jump_count(jc0)
    );

    snoopy_vertical_physics #(.CEIL_Y(90)) dut1 (
        .clock(clk), .reset(rst), .frame_tick(tick), .jump_in(jin),
        .snoopy_y(y1), .velocity(v1), .on_ground(og1), .landed(ld1), .jump_count(jc1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int m, input bit r, input bit t, input bit j);
        int edge_seen, want, v, yn;
        if (r) begin
            m_y[m] = GND; m_v[m] = 0; m_air[m] = 0; m_rise[m] = 0;
            m_cnt[m] = 0; m_land[m] = 0; m_req[m] = 0; m_prev[m] = 0;
            return;
        end
        edge_seen = (j && !m_prev[m]) ? 1 : 0;
        m_prev[m] = j;
        m_land[m] = 0;
        if (!t) begin
            if (edge_seen != 0) m_req[m] = 1;
            return;
        end
        want = (m_req[m] != 0 || edge_seen != 0) ? 1 : 0;
        m_req[m] = 0;
        if (want != 0 && (m_air[m] == 0 || m_cnt[m] < MAXJ)) begin
            m_cnt[m]  = (m_air[m] == 0) ? 1 : m_cnt[m] + 1;
            m_air[m]  = 1;
            m_rise[m] = 1;
            m_v[m]    = -JV;
            m_y[m]    = (m_y[m] - JV < m_ceil[m]) ? m_ceil[m] : m_y[m] - JV;
        end else if (m_air[m] != 0) begin
            v = m_v[m];
`ifdef SNOOPY_VAR_JUMP_EN
            if (m_rise[m] != 0 && !j && v < -1) v = v >>> 1;
`endif
            v  = v + GRAV;
            if (v > MAXF) v = MAXF;
            yn = m_y[m] + v;
            if (yn >= GND) begin
                m_y[m] = GND; m_v[m] = 0; m_cnt[m] = 0; m_air[m] = 0; m_rise[m] = 0; m_land[m] = 1;
            end else if (yn <= m_ceil[m]) begin
                m_y[m] = m_ceil[m]; m_v[m] = 0; m_rise[m] = 0;
            end else begin
                m_y[m] = yn; m_v[m] = v; m_rise[m] = (v < 0) ? 1 : 0;
            end
        end
    endtask

    task automatic compare_inst(input int m, input int y, input int v, input int og,
                                input int ld, input int jc);
        string s;
        s = (m == 0) ? "d0" : "d1";
        check({s, "_y"}, y, m_y[m]);
        check({s, "_vel"}, v, m_v[m]);
        check({s, "_on_ground"}, og, (m_air[m] == 0) ? 1 : 0);
        check({s, "_landed"}, ld, m_land[m]);
        check({s, "_jump_count"}, jc, m_cnt[m]);
    endtask

    task automatic cyc(input bit t, input bit j, input bit r);
        tick = t; jin = j; rst = r;
        @(posedge clk);
        model_step(0, r, t, j);
        model_step(1, r, t, j);
        #1;
        compare_inst(0, int'(y0), int'(v0), int'(og0), int'(ld0), int'(jc0));
        compare_inst(1, int'(y1), int'(v1), int'(og1), int'(ld1), int'(jc1));
    endtask

    task automatic fly_to_ground();
        for (int k = 0; k < 60 && !og0; k++) cyc(1'b1, 1'b0, 1'b0);
        check("returned_to_ground", int'(og0), 1);
    endtask

    initial begin
        int   min_y;
        bit   jl;
        // Reset state
        cyc(1'b0, 1'b0, 1'b1);
        check("rst_y", int'(y0), 100);
        check("rst_vel", int'(v0), 0);
        check("rst_on_ground", int'(og0), 1);
        check("rst_landed", int'(ld0), 0);
        check("rst_jump_count", int'(jc0), 0);
        cyc(1'b0, 1'b0, 1'b0);

        // Single jump from a press between ticks; ceiling instance bumps at t2
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        min_y = 255;
        for (int k = 1; k <= 13; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (int'(y0) < min_y) min_y = int'(y0);
`ifndef SNOOPY_VAR_JUMP_EN
            check($sformatf("sj_y_t%0d", k), int'(y0), sj_tbl[k-1]);
            check($sformatf("sj_landed_t%0d", k), int'(ld0), (k == 13) ? 1 : 0);
            if (k == 1) check("sj_count_t1", int'(jc0), 1);
            if (k == 7) check("sj_apex_fall", int'(og0), 0);
            if (k == 1) check("ceil_y_t1", int'(y1), 94);
            if (k == 2) check("ceil_y_t2", int'(y1), 90);
            if (k == 2) check("ceil_vel_t2", int'(v1), 0);
`endif
            cyc(1'b0, 1'b0, 1'b0);
            check("landed_pulse_only_on_tick", int'(ld0), 0);
        end
`ifdef SNOOPY_VAR_JUMP_EN
        check("var_short_apex_below_full", (min_y > 79) ? 1 : 0, 1);
`endif
        fly_to_ground();

        // Double jump, third press dropped, then reset mid-air
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("dj_vel", int'(v0), -6);
        check("dj_count", int'(jc0), 2);
        check("dj_y", int'(y0), 88);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("third_press_count", int'(jc0), 2);
`ifndef SNOOPY_VAR_JUMP_EN
        check("third_press_vel", int'(v0), -5);
`endif
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check("midair_rst_y", int'(y0), 100);
        check("midair_rst_vel", int'(v0), 0);
        check("midair_rst_on_ground", int'(og0), 1);
        check("midair_rst_count", int'(jc0), 0);
        check("midair_rst_landed", int'(ld0), 0);

        // Held level across three ticks gives exactly one jump
        for (int c = 0; c < 50; c++) cyc((c % 15) == 10, 1'b1, 1'b0);
        check("held_one_jump", int'(jc0), 1);
        check("held_airborne", int'(og0), 0);
        fly_to_ground();
        cyc(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("between_tick_press", int'(jc0), 1);
        fly_to_ground();

        // Randomised traffic against the model
        jl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 4) == 0) jl = ~jl;
            cyc($urandom_range(0, 3) == 0, jl, $urandom_range(0, 799) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
